// File: rtl/history_buffer_mc.sv
// Multi-channel circular history buffer: per-channel DEPTH-word history with a
// valid/ready write port and an oldest-to-newest, zero-padded readout stream.
module history_buffer_mc #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 28,
    parameter int CHANNELS = 2,
    localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int AW      = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                clr,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CW-1:0]       in_ch,
    input  logic [WIDTH-1:0]    in_data,
    input  logic                rd_start,
    input  logic [CW-1:0]       rd_ch,
    output logic                busy,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_data,
    output logic [AW-1:0]       out_idx,
    output logic                out_last,
    output logic [CHANNELS-1:0] full
);

    // Handshakes: a word moves on a rising edge where valid && ready; the
    // sender holds its payload stable while valid is high and ready is low.

    localparam logic [AW:0]   DEPTH_X  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] DEPTH_A  = AW'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    localparam logic [CW:0]   CH_LIM   = (CW+1)'(CHANNELS);

    typedef enum logic [0:0] {S_IDLE, S_STREAM} state_t;

    state_t              r_state, w_state_nxt;
    logic [WIDTH-1:0]    r_mem    [CHANNELS][DEPTH];
    logic [AW-1:0]       r_wr_ptr [CHANNELS];
    logic [AW-1:0]       r_fill   [CHANNELS];
    logic [AW-1:0]       w_ptr_nxt  [CHANNELS];
    logic [AW-1:0]       w_fill_nxt [CHANNELS];
    logic [CHANNELS-1:0] r_full;
    logic [CHANNELS-1:0] w_wr_sel;

    logic [CW-1:0]       r_rd_ch, w_rd_ch_nxt;
    logic [AW-1:0]       r_snap_ptr, w_snap_ptr_nxt;
    logic [AW-1:0]       r_snap_fill, w_snap_fill_nxt;
    logic                r_out_valid, w_out_valid_nxt;
    logic [WIDTH-1:0]    r_out_data, w_out_data_nxt;
    logic [AW-1:0]       r_out_idx, w_out_idx_nxt;
    logic                r_out_last, w_out_last_nxt;

    logic                w_in_ch_ok, w_rd_ch_ok, w_wr_acc;
    logic [AW-1:0]       w_start_ptr, w_start_fill;
    logic [CW-1:0]       w_sel_ch;
    logic [AW-1:0]       w_sel_ptr, w_sel_fill, w_sel_k, w_addr;
    logic [AW:0]         w_pad_sum, w_addr_sum;
    logic [WIDTH-1:0]    w_word;

    assign w_in_ch_ok = ({1'b0, in_ch} < CH_LIM);
    assign w_rd_ch_ok = ({1'b0, rd_ch} < CH_LIM);
    assign busy       = (r_state == S_STREAM);
    assign in_ready   = !clr && w_in_ch_ok && !(busy && (in_ch == r_rd_ch));
    assign w_wr_acc   = in_valid && in_ready;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_idx    = r_out_idx;
    assign out_last   = r_out_last;
    assign full       = r_full;

    // Post-write pointer/fill per channel; also the snapshot taken on rd_start.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            w_wr_sel[c]   = w_wr_acc && (in_ch == CW'(c));
            w_ptr_nxt[c]  = r_wr_ptr[c];
            w_fill_nxt[c] = r_fill[c];
            if (w_wr_sel[c]) begin
                w_ptr_nxt[c]  = (r_wr_ptr[c] == LAST_IDX) ? '0 : r_wr_ptr[c] + AW'(1);
                w_fill_nxt[c] = (r_fill[c] == DEPTH_A) ? r_fill[c] : r_fill[c] + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int c = 0; c < CHANNELS; c++) begin
                for (int d = 0; d < DEPTH; d++) begin
                    r_mem[c][d] <= '0;
                end
                r_wr_ptr[c] <= '0;
                r_fill[c]   <= '0;
            end
            r_full <= '0;
        end else if (clr) begin
            // Stale storage is masked by zero padding, so only indices reset.
            for (int c = 0; c < CHANNELS; c++) begin
                r_wr_ptr[c] <= '0;
                r_fill[c]   <= '0;
            end
            r_full <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (w_wr_sel[c]) begin
                    r_mem[c][r_wr_ptr[c]] <= in_data;
                end
                r_wr_ptr[c] <= w_ptr_nxt[c];
                r_fill[c]   <= w_fill_nxt[c];
                r_full[c]   <= (w_fill_nxt[c] == DEPTH_A);
            end
        end
    end

    // Word fetch: word 0 of a new stream in IDLE, otherwise the word after out_idx.
    always_comb begin
        w_start_ptr  = '0;
        w_start_fill = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (rd_ch == CW'(c)) begin
                w_start_ptr  = w_ptr_nxt[c];
                w_start_fill = w_fill_nxt[c];
            end
        end
        w_sel_ch   = r_rd_ch;
        w_sel_ptr  = r_snap_ptr;
        w_sel_fill = r_snap_fill;
        w_sel_k    = r_out_idx + AW'(1);
        if (r_state == S_IDLE) begin
            w_sel_ch   = rd_ch;
            w_sel_ptr  = w_start_ptr;
            w_sel_fill = w_start_fill;
            w_sel_k    = '0;
        end
        w_pad_sum  = {1'b0, w_sel_k} + {1'b0, w_sel_fill};
        w_addr_sum = {1'b0, w_sel_ptr} + {1'b0, w_sel_k};
        w_addr     = (w_addr_sum >= DEPTH_X) ? AW'(w_addr_sum - DEPTH_X) : AW'(w_addr_sum);
        w_word     = '0;
        if (w_pad_sum >= DEPTH_X) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (w_sel_ch == CW'(c)) begin
                    w_word = r_mem[c][w_addr];
                end
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_out_valid_nxt = r_out_valid;
        w_out_data_nxt  = r_out_data;
        w_out_idx_nxt   = r_out_idx;
        w_out_last_nxt  = r_out_last;
        w_rd_ch_nxt     = r_rd_ch;
        w_snap_ptr_nxt  = r_snap_ptr;
        w_snap_fill_nxt = r_snap_fill;
        case (r_state)
            S_IDLE: begin
                if (rd_start && w_rd_ch_ok && !clr) begin
                    w_state_nxt     = S_STREAM;
                    w_out_valid_nxt = 1'b1;
                    w_out_data_nxt  = w_word;
                    w_out_idx_nxt   = '0;
                    w_out_last_nxt  = 1'b0;
                    w_rd_ch_nxt     = rd_ch;
                    w_snap_ptr_nxt  = w_start_ptr;
                    w_snap_fill_nxt = w_start_fill;
                end
            end
            S_STREAM: begin
                if (clr || (r_out_valid && out_ready && r_out_last)) begin
                    w_state_nxt     = S_IDLE;
                    w_out_valid_nxt = 1'b0;
                    w_out_data_nxt  = '0;
                    w_out_idx_nxt   = '0;
                    w_out_last_nxt  = 1'b0;
                end else if (r_out_valid && out_ready) begin
                    w_out_data_nxt  = w_word;
                    w_out_idx_nxt   = w_sel_k;
                    w_out_last_nxt  = (w_sel_k == LAST_IDX);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
            r_rd_ch     <= '0;
            r_snap_ptr  <= '0;
            r_snap_fill <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_idx   <= w_out_idx_nxt;
            r_out_last  <= w_out_last_nxt;
            r_rd_ch     <= w_rd_ch_nxt;
            r_snap_ptr  <= w_snap_ptr_nxt;
            r_snap_fill <= w_snap_fill_nxt;
        end
    end

endmodule

// File: tb/tb_history_buffer_mc.sv
// Bench for history_buffer_mc: shift-register reference model per channel,
// expected-word queue filled on accepted rd_start, negedge monitor pops/compares.
module tb_history_buffer_mc;

    localparam int WIDTH    = 32;
    localparam int DEPTH    = 28;
    localparam int CHANNELS = 2;
    localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int AW       = $clog2(DEPTH + 1);
    localparam int EW       = AW + WIDTH;

    logic                clk;
    logic                rstn;
    logic                clr;
    logic                in_valid;
    logic                in_ready;
    logic [CW-1:0]       in_ch;
    logic [WIDTH-1:0]    in_data;
    logic                rd_start;
    logic [CW-1:0]       rd_ch;
    logic                busy;
    logic                out_valid;
    logic                out_ready;
    logic [WIDTH-1:0]    out_data;
    logic [AW-1:0]       out_idx;
    logic                out_last;
    logic [CHANNELS-1:0] full;

    history_buffer_mc #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CHANNELS(CHANNELS)) dut (
        .clk(clk), .rstn(rstn), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .in_data(in_data),
        .rd_start(rd_start), .rd_ch(rd_ch), .busy(busy),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last), .full(full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a zero-initialised shift register per channel, oldest at 0.
    logic [WIDTH-1:0] hist [CHANNELS][DEPTH];
    int               m_fill [CHANNELS];
    logic             m_busy;
    int               m_ch;
    logic [EW-1:0]    exp_q[$];
    logic             mon_en;
    logic             prev_stall;
    logic [WIDTH-1:0] prev_data;
    logic [AW-1:0]    prev_idx;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CHANNELS; c++) begin
            for (int d = 0; d < DEPTH; d++) hist[c][d] = '0;
            m_fill[c] = 0;
        end
        m_busy     = 1'b0;
        m_ch       = 0;
        prev_stall = 1'b0;
        exp_q.delete();
    endtask

    // Monitor: compares state seen mid-cycle, then applies the coming edge to the model.
    always @(negedge clk) begin : monitor
        logic                exp_ready;
        logic                busy_pre;
        logic                start_ok;
        logic [CHANNELS-1:0] exp_full;
        logic [EW-1:0]       e;
        if (rstn && mon_en) begin
            busy_pre = m_busy;
            for (int c = 0; c < CHANNELS; c++) exp_full[c] = (m_fill[c] == DEPTH);
            chk("full", 64'(full), 64'(exp_full));
            chk("busy", 64'(busy), 64'(m_busy));
            chk("out_valid", 64'(out_valid), 64'(m_busy));
            exp_ready = !clr && (int'(in_ch) < CHANNELS) && !(m_busy && int'(in_ch) == m_ch);
            chk("in_ready", 64'(in_ready), 64'(exp_ready));
            if (out_valid && prev_stall) begin
                chk("stall_hold_data", 64'(out_data), 64'(prev_data));
                chk("stall_hold_idx", 64'(out_idx), 64'(prev_idx));
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_idx   = out_idx;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_word: got idx %0d data %0h, expected none", out_idx, out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_idx", 64'(out_idx), 64'(e[EW-1:WIDTH]));
                    chk("out_data", 64'(out_data), 64'(e[WIDTH-1:0]));
                    chk("out_last", 64'(out_last), 64'(e[EW-1:WIDTH] == AW'(DEPTH - 1)));
                    if (e[EW-1:WIDTH] == AW'(DEPTH - 1)) m_busy = 1'b0;
                end
            end
            start_ok = !busy_pre && rd_start && (int'(rd_ch) < CHANNELS) && !clr;
            if (clr) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    for (int d = 0; d < DEPTH; d++) hist[c][d] = '0;
                    m_fill[c] = 0;
                end
                m_busy     = 1'b0;
                prev_stall = 1'b0;
                exp_q.delete();
            end else begin
                if (in_valid && exp_ready) begin
                    for (int d = 0; d < DEPTH - 1; d++) hist[in_ch][d] = hist[in_ch][d+1];
                    hist[in_ch][DEPTH-1] = in_data;
                    if (m_fill[in_ch] < DEPTH) m_fill[in_ch]++;
                end
                if (start_ok) begin
                    for (int k = 0; k < DEPTH; k++) exp_q.push_back({AW'(k), hist[rd_ch][k]});
                    m_busy = 1'b1;
                    m_ch   = int'(rd_ch);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic write_word(input int ch, input logic [WIDTH-1:0] d);
        in_valid = 1'b1;
        in_ch    = CW'(ch);
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    // mode 0: always ready; 1: ready 1,0,0,1 with writes to both channels; 2: random ready
    task automatic wait_idle(input int mode);
        for (int i = 0; i < 400; i++) begin
            if (!busy) break;
            case (mode)
                1: begin
                    out_ready = (i % 4 == 0) || (i % 4 == 3);
                    in_valid  = 1'b1;
                    in_ch     = CW'(i % 2);
                    in_data   = $urandom;
                end
                2: out_ready = ($urandom_range(0, 1) == 1);
                default: out_ready = 1'b1;
            endcase
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream_done", 64'(busy), 64'(0));
    endtask

    task automatic start_stream(input int ch);
        rd_start = 1'b1;
        rd_ch    = CW'(ch);
        step();
        rd_start = 1'b0;
    endtask

    task automatic wait_idx(input int k);
        for (int i = 0; i < 100; i++) begin
            if (out_valid && int'(out_idx) == k) break;
            step();
        end
        chk("reach_idx", 64'(out_idx), 64'(k));
    endtask

    initial begin
        rstn = 1'b0; clr = 1'b0; in_valid = 1'b0; in_ch = '0; in_data = '0;
        rd_start = 1'b0; rd_ch = '0; out_ready = 1'b1; mon_en = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_out_idx", 64'(out_idx), 64'(0));
        chk("rst_out_last", 64'(out_last), 64'(0));
        chk("rst_full", 64'(full), 64'(0));
        rstn   = 1'b1;
        mon_en = 1'b1;
        step();

        // Single sample on ch0, streamed with padding.
        write_word(0, 32'h3F80_0000);
        start_stream(0);
        wait_idle(0);

        // 30 samples on ch1: wraps and saturates.
        for (int i = 1; i <= 30; i++) write_word(1, WIDTH'(i));
        start_stream(1);
        wait_idle(0);

        // Stalling stream on ch0 with concurrent writes to both channels.
        start_stream(0);
        wait_idle(1);

        // rd_start and same-channel write in the same cycle.
        in_valid = 1'b1; in_ch = '0; in_data = 32'h4000_0000;
        rd_start = 1'b1; rd_ch = '0;
        step();
        in_valid = 1'b0; rd_start = 1'b0;
        wait_idle(0);

        // Back-to-back streams: rd_start held through the first stream's end.
        start_stream(1);
        rd_start = 1'b1; rd_ch = '0;
        for (int i = 0; i < 60; i++) begin
            if (!busy) break;
            step();
        end
        step();
        rd_start = 1'b0;
        wait_idle(2);

        // clr at the 10th word aborts; next stream is all zeros.
        start_stream(1);
        wait_idx(9);
        clr = 1'b1;
        step();
        clr = 1'b0;
        step();
        start_stream(0);
        wait_idle(0);

        // Async reset at the 10th word with ch1 full.
        for (int i = 0; i < DEPTH; i++) write_word(1, $urandom);
        write_word(0, 32'hDEAD_BEEF);
        start_stream(0);
        wait_idx(9);
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("async_out_valid", 64'(out_valid), 64'(0));
        chk("async_busy", 64'(busy), 64'(0));
        chk("async_full", 64'(full), 64'(0));
        mon_en = 1'b0;
        model_reset();
        step();
        rstn   = 1'b1;
        mon_en = 1'b1;
        step();
        start_stream(0);
        wait_idle(0);

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            in_ch     = CW'($urandom_range(0, CHANNELS - 1));
            in_data   = $urandom;
            rd_start  = ($urandom_range(0, 9) == 0);
            rd_ch     = CW'($urandom_range(0, CHANNELS - 1));
            out_ready = ($urandom_range(0, 3) != 0);
            clr       = ($urandom_range(0, 149) == 0);
            step();
        end
        in_valid = 1'b0; rd_start = 1'b0; clr = 1'b0;
        wait_idle(0);
        chk("queue_drained", 64'(exp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/history_buffer_mc.md
Name: history_buffer_mc

Overview:
- Multi-channel, clocked successor to the single-channel edge-triggered history shifter used ahead of the DFT datapath.
- Keeps the last DEPTH IEEE754 words per channel in circular storage, with a valid/ready write port.
- On request, streams one channel's history oldest-to-newest over a valid/ready read port, with zero padding until that channel has filled.
- Sits between the sample acquisition front end and the DFT engine.

Parameters:
- WIDTH, 32, data word width in bits (IEEE754 single by default)
- DEPTH, 28, history length per channel; any value >= 2, need not be a power of two
- CHANNELS, 2, number of independent histories; >= 1
- CW, derived = max(1, clog2(CHANNELS)), channel index width (localparam)
- AW, derived = clog2(DEPTH+1), index/count width (localparam)

Ports:
- clk  in  1  rising-edge clock
- rstn  in  1  reset, asynchronous, active-low
- clr  in  1  synchronous clear of all histories, high for one or more cycles
- in_valid  in  1  write request
- in_ready  out  1  write accept
- in_ch  in  CW  target channel of write
- in_data  in  WIDTH  sample to append
- rd_start  in  1  one-cycle request to stream a channel's history
- rd_ch  in  CW  channel to stream
- busy  out  1  readout in progress
- out_valid  out  1  stream word valid
- out_ready  in  1  stream word accept
- out_data  out  WIDTH  stream word
- out_idx  out  AW  position of out_data, 0 = oldest, DEPTH-1 = newest
- out_last  out  1  high with out_idx == DEPTH-1
- full  out  CHANNELS  bit c high once channel c holds DEPTH samples since last clear/reset

Behaviour:
- Reset (rstn low, async): all storage zero, all wr_ptr/fill zero, FSM IDLE. Outputs: busy=0, out_valid=0, out_data=0, out_idx=0, out_last=0, full=0. in_ready is combinational and may be high during reset.
- Write: a word is accepted when in_valid && in_ready at a rising edge. It is stored at wr_ptr[in_ch].
  - wr_ptr wraps DEPTH-1 -> 0.
  - fill[in_ch] increments, saturating at DEPTH.
  - full[c] = (fill[c] == DEPTH), registered and visible the cycle after the DEPTH-th accepted write.
- in_ready = !clr && (in_ch < CHANNELS) && !(busy && in_ch == rd_ch_latched). Writes to channels not being streamed proceed during readout. Writes to an out-of-range channel are never accepted.
- Readout FSM states: IDLE, STREAM.
  - IDLE -> STREAM on rd_start && rd_ch < CHANNELS && !clr; rd_ch is latched. rd_start in STREAM or with an invalid rd_ch is ignored.
  - Snapshot: wr_ptr/fill of the latched channel as of the end of the rd_start cycle. A write to the same channel accepted in that cycle is included as the newest word.
  - rd_start in cycle N -> out_valid=1, out_idx=0 registered in cycle N+1. busy=1 from N+1 until return to IDLE.
  - Word k: if k < DEPTH - fill, out_data = 0; else out_data = mem[ch][(wr_ptr + k) mod DEPTH]. This gives oldest first and newest at k = DEPTH-1, matching the zero-initialised shift-register semantics.
  - out_data, out_idx and out_last are held stable while out_valid && !out_ready.
  - On each handshake, out_idx advances and the next word is registered with no bubble.
  - Handshake with out_last=1 -> IDLE next cycle, with out_valid=0, busy=0. Back-to-back rd_start is accepted in that IDLE cycle.
- clr: at the edge, all fill and wr_ptr are zeroed and all full bits cleared; storage need not be cleared because zero padding covers it. In STREAM, clr aborts: next cycle out_valid=0, busy=0, IDLE. clr wins over a simultaneous write or rd_start.
- Reset mid-stream: immediate return to reset state. No partial word is presented after rstn rises.
- Mod arithmetic uses a compare-and-subtract on an AW+1-bit sum; no power-of-two assumption.

Test Plan:
- Reset, write 0x3F800000 (1.0) to ch0, rd_start ch0 -> 28 words; idx 0..26 = 0, idx 27 = 0x3F800000 with out_last=1; full=2'b00.
- Write 30 words 1..30 (as integers) to ch1, stream ch1 -> idx 0..27 = 3..30; full[1] rises the cycle after the 28th write, full[0]=0.
- Stream ch0 with out_ready toggling 1,0,0,1 -> data/idx held during stalls, exactly 28 handshakes, no duplicates or skips.
- During ch0 stream, offer writes to ch0 and ch1 -> in_ready=0 for ch0, 1 for ch1; ch1 count advances, ch0 stream content unchanged.
- Same-cycle rd_start ch0 and write 0x40000000 to ch0 -> first out_valid next cycle; idx 27 = 0x40000000.
- Assert clr at the 10th word of a stream -> out_valid/busy low next cycle, full=0; subsequent stream returns all zeros. Repeat with rstn pulsed instead -> same result, asynchronously.
